// File: rtl/accumulator_pkg.sv
// Shared types for the accumulator bank: command opcodes and shift-sequencer states.
// Used by acc_shift_ctrl and accumulator_bank.
package accumulator_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_LOADB = 3'b010,
        OP_INC   = 3'b011,
        OP_DEC   = 3'b100,
        OP_SHL   = 3'b101,
        OP_SHR   = 3'b110,
        OP_CLR   = 3'b111
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic isShiftOp(input op_t op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/acc_shift_ctrl.sv
// Command sequencer for the accumulator bank: accepts commands when idle and
// walks multi-cycle shifts one bit per cycle, generating Busy and Done.
module acc_shift_ctrl
    import accumulator_pkg::*;
#(
    parameter int unsigned SW = 2,
    parameter int unsigned CW = 3
) (
    input  logic          MainClock,
    input  logic          Clear,
    input  logic          Latch,
    input  op_t           Op,
    input  logic [SW-1:0] WrSel,
    input  logic [CW-1:0] ShAmt,
    output logic          cmdAccept_c,
    output logic          shiftStep_c,
    output logic          shiftLeft,
    output logic [SW-1:0] shiftSel,
    output logic          Busy,
    output logic          Done
);

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic          leftNext;
    logic [SW-1:0] selNext;
    logic          doneNext;

    // State and shift context registers; Clear aborts any shift in flight.
    always_ff @(posedge MainClock) begin
        if (Clear) begin
            state     <= IDLE;
            count     <= '0;
            shiftLeft <= 1'b0;
            shiftSel  <= '0;
            Done      <= 1'b0;
        end else begin
            state     <= stateNext;
            count     <= countNext;
            shiftLeft <= leftNext;
            shiftSel  <= selNext;
            Done      <= doneNext;
        end
    end

    always_comb begin
        stateNext   = state;
        countNext   = count;
        leftNext    = shiftLeft;
        selNext     = shiftSel;
        doneNext    = 1'b0;
        cmdAccept_c = 1'b0;
        shiftStep_c = 1'b0;
        case (state)
            IDLE: begin
                if (Latch) begin
                    cmdAccept_c = 1'b1;
                    if (isShiftOp(Op) && (ShAmt != '0)) begin
                        stateNext = SHIFT;
                        countNext = ShAmt;
                        leftNext  = (Op == OP_SHL);
                        selNext   = WrSel;
                    end else begin
                        doneNext = 1'b1;
                    end
                end
            end
            SHIFT: begin
                shiftStep_c = 1'b1;
                countNext   = count - CW'(1);
                if (count == CW'(1)) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign Busy = (state == SHIFT);

endmodule

// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC accumulators with load/inc/dec/clear and multi-cycle shifts,
// one read port to the ALU and an inverting bus driver. Flags built with ACC_FLAGS_EN.
module accumulator_bank
    import accumulator_pkg::*;
#(
    parameter  int unsigned WIDTH   = 4,
    parameter  int unsigned NUM_ACC = 4,
    localparam int unsigned SW      = $clog2(NUM_ACC),
    localparam int unsigned CW      = $clog2(WIDTH) + 1
) (
    input  logic             MainClock,
    input  logic             Clear,
    input  logic             Latch,
    input  logic [2:0]       Op,
    input  logic [SW-1:0]    WrSel,
    input  logic [CW-1:0]    ShAmt,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [WIDTH-1:0] BusIn,
    input  logic [SW-1:0]    RdSel,
    input  logic             Enable,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] IB,
    output logic             IBOe,
    output logic             Busy,
    output logic             Done,
    output logic             Zero,
    output logic             Carry
);

    logic [WIDTH-1:0] acc [NUM_ACC];
    op_t              opC;
    logic             cmdAccept_c;
    logic             shiftStep_c;
    logic             shiftLeft;
    logic [SW-1:0]    shiftSel;
    logic             wrEn;
    logic [SW-1:0]    wrIdx;
    logic [WIDTH-1:0] wrVal;

    assign opC = op_t'(Op);

    acc_shift_ctrl #(
        .SW(SW),
        .CW(CW)
    ) uCtrl (
        .MainClock  (MainClock),
        .Clear      (Clear),
        .Latch      (Latch),
        .Op         (opC),
        .WrSel      (WrSel),
        .ShAmt      (ShAmt),
        .cmdAccept_c(cmdAccept_c),
        .shiftStep_c(shiftStep_c),
        .shiftLeft  (shiftLeft),
        .shiftSel   (shiftSel),
        .Busy       (Busy),
        .Done       (Done)
    );

    // Write mux: a shift step in progress owns the write port, otherwise the accepted command.
    always_comb begin
        wrEn  = 1'b0;
        wrIdx = WrSel;
        wrVal = '0;
        if (shiftStep_c) begin
            wrEn  = 1'b1;
            wrIdx = shiftSel;
            wrVal = shiftLeft ? (acc[shiftSel] << 1) : (acc[shiftSel] >> 1);
        end else if (cmdAccept_c) begin
            case (opC)
                OP_LOAD: begin
                    wrEn  = 1'b1;
                    wrVal = DataIn;
                end
                OP_LOADB: begin
                    wrEn  = 1'b1;
                    wrVal = BusIn;
                end
                OP_INC: begin
                    wrEn  = 1'b1;
                    wrVal = acc[WrSel] + WIDTH'(1);
                end
                OP_DEC: begin
                    wrEn  = 1'b1;
                    wrVal = acc[WrSel] - WIDTH'(1);
                end
                OP_CLR: begin
                    wrEn  = 1'b1;
                    wrVal = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge MainClock) begin
        if (Clear) begin
            acc <= '{default: '0};
        end else if (wrEn) begin
            acc[wrIdx] <= wrVal;
        end
    end

    // Read side is combinational; bus enable is held off so partial shifts never leak.
    assign AluA = acc[RdSel];
    assign IB   = ~acc[RdSel];
    assign IBOe = Enable & ~Busy;

`ifdef ACC_FLAGS_EN
    logic zeroQ;
    logic carryQ;
    logic carryNext;

    // Carry is the wrap of inc/dec or the bit leaving the register on a shift step.
    always_comb begin
        carryNext = 1'b0;
        if (shiftStep_c) begin
            carryNext = shiftLeft ? acc[shiftSel][WIDTH-1] : acc[shiftSel][0];
        end else if (opC == OP_INC) begin
            carryNext = &acc[WrSel];
        end else if (opC == OP_DEC) begin
            carryNext = ~|acc[WrSel];
        end
    end

    always_ff @(posedge MainClock) begin
        if (Clear) begin
            zeroQ  <= 1'b0;
            carryQ <= 1'b0;
        end else if (wrEn) begin
            zeroQ  <= (wrVal == '0);
            carryQ <= carryNext;
        end
    end

    assign Zero  = zeroQ;
    assign Carry = carryQ;
`else
    assign Zero  = 1'b0;
    assign Carry = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_bank.sv
// Self-checking bench for accumulator_bank: directed vector table, an abort sequence,
// and randomized traffic against a cycle-count based reference model.
module tb_accumulator_bank;

    localparam int W = 4;
`ifdef ACC_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       MainClock = 1'b0;
    logic       Clear, Latch, Enable;
    logic [2:0] Op;
    logic [1:0] WrSel, RdSel;
    logic [2:0] ShAmt;
    logic [3:0] DataIn, BusIn;
    logic [3:0] AluA, IB;
    logic       IBOe, Busy, Done, Zero, Carry;

    int checks = 0;
    int errors = 0;

    always #5 MainClock = ~MainClock;

    accumulator_bank #(.WIDTH(4), .NUM_ACC(4)) dut (
        .MainClock(MainClock), .Clear(Clear), .Latch(Latch), .Op(Op),
        .WrSel(WrSel), .ShAmt(ShAmt), .DataIn(DataIn), .BusIn(BusIn),
        .RdSel(RdSel), .Enable(Enable), .AluA(AluA), .IB(IB), .IBOe(IBOe),
        .Busy(Busy), .Done(Done), .Zero(Zero), .Carry(Carry)
    );

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge MainClock);
        #1;
    endtask

    // Directed vector: inputs applied for one edge, expected outputs after it.
    typedef struct {
        int clr, lat, op, wr, sh, din, bin, rd, en;
        int aluA, ioe, busy, done, zero, carry;
    } vec_t;
    vec_t vecs[14];

    // Reference model: shifts are tracked by elapsed cycles from the start value.
    int accM[4];
    bit busyM, doneM, zeroM, carryM;
    int shTgt, shStart, shN, shK;
    bit shLeft;

    task automatic mWrite(input int idx, input int val, input bit c);
        accM[idx] = val;
        zeroM     = (val == 0);
        carryM    = c;
    endtask

    task automatic modelEdge();
        int v;
        if (Clear) begin
            foreach (accM[i]) accM[i] = 0;
            busyM = 0; doneM = 0; zeroM = 0; carryM = 0;
            return;
        end
        doneM = 0;
        if (busyM) begin
            shK++;
            if (shLeft) begin
                accM[shTgt] = (shStart << shK) % 16;
                carryM      = ((shStart << shK) >> W) & 1;
            end else begin
                accM[shTgt] = shStart >> shK;
                carryM      = (shStart >> (shK - 1)) & 1;
            end
            zeroM = (accM[shTgt] == 0);
            if (shK == shN) begin
                busyM = 0;
                doneM = 1;
            end
        end else if (Latch) begin
            v = accM[WrSel];
            case (Op)
                3'd1: mWrite(int'(WrSel), int'(DataIn), 1'b0);
                3'd2: mWrite(int'(WrSel), int'(BusIn), 1'b0);
                3'd3: mWrite(int'(WrSel), (v + 1) % 16, v == 15);
                3'd4: mWrite(int'(WrSel), (v + 15) % 16, v == 0);
                3'd7: mWrite(int'(WrSel), 0, 1'b0);
                3'd5, 3'd6: begin
                    if (ShAmt != 3'd0) begin
                        busyM = 1; shTgt = int'(WrSel); shLeft = (Op == 3'd5);
                        shStart = v; shN = int'(ShAmt); shK = 0;
                    end
                end
                default: ;
            endcase
            if (!busyM) doneM = 1;
        end
    endtask

    initial begin
        Clear = 1'b1; Latch = 1'b0; Op = 3'd0; WrSel = 2'd0; ShAmt = 3'd0;
        DataIn = 4'd0; BusIn = 4'd0; RdSel = 2'd0; Enable = 1'b0;

        //            clr lat op wr sh din  bin rd en | aluA ioe busy done zero carry
        vecs[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0,   0,   0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0,   0, 1, 0,   0,   0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 2, 0, 'hA, 0, 2, 0,   'hA, 0, 0, 1, 0, 0};
        vecs[3]  = '{0, 1, 2, 1, 0, 0,   5, 2, 1,   'hA, 1, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0,   0, 1, 1,   5,   1, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 1, 0, 0, 'hF, 0, 0, 0,   'hF, 0, 0, 1, 0, 0};
        vecs[6]  = '{0, 1, 3, 0, 0, 0,   0, 0, 0,   0,   0, 0, 1, 1, 1};
        vecs[7]  = '{0, 1, 4, 0, 0, 0,   0, 0, 0,   'hF, 0, 0, 1, 0, 1};
        vecs[8]  = '{0, 1, 1, 3, 0, 3,   0, 3, 0,   3,   0, 0, 1, 0, 0};
        vecs[9]  = '{0, 1, 5, 3, 2, 0,   0, 3, 1,   3,   0, 1, 0, 0, 0};
        vecs[10] = '{0, 1, 1, 3, 0, 9,   0, 3, 1,   6,   0, 1, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0,   0, 3, 1,   'hC, 1, 0, 1, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0,   0, 3, 1,   'hC, 1, 0, 0, 0, 0};
        vecs[13] = '{0, 1, 6, 3, 0, 0,   0, 3, 0,   'hC, 0, 0, 1, 0, 0};

        foreach (vecs[i]) begin
            Clear = 1'(vecs[i].clr); Latch = 1'(vecs[i].lat); Op = 3'(vecs[i].op);
            WrSel = 2'(vecs[i].wr); ShAmt = 3'(vecs[i].sh); DataIn = 4'(vecs[i].din);
            BusIn = 4'(vecs[i].bin); RdSel = 2'(vecs[i].rd); Enable = 1'(vecs[i].en);
            tick();
            check($sformatf("vec%0d_aluA", i), 32'(AluA), vecs[i].aluA);
            check($sformatf("vec%0d_ib", i), 32'(IB), (~vecs[i].aluA) & 'hF);
            check($sformatf("vec%0d_iboe", i), 32'(IBOe), vecs[i].ioe);
            check($sformatf("vec%0d_busy", i), 32'(Busy), vecs[i].busy);
            check($sformatf("vec%0d_done", i), 32'(Done), vecs[i].done);
            check($sformatf("vec%0d_zero", i), 32'(Zero), FLAGS ? vecs[i].zero : 0);
            check($sformatf("vec%0d_carry", i), 32'(Carry), FLAGS ? vecs[i].carry : 0);
        end

        // Same-cycle write/read shows the old value before the edge, new after.
        Latch = 1'b1; Op = 3'd1; WrSel = 2'd1; DataIn = 4'h8; RdSel = 2'd1; Enable = 1'b0;
        #1;
        check("rw_old", 32'(AluA), 5);
        tick();
        check("rw_new", 32'(AluA), 8);

        // Abort: SHR by 3 on 1000, one step, then Clear.
        Op = 3'd6; ShAmt = 3'd3;
        tick();
        check("abort_busy0", 32'(Busy), 1);
        Latch = 1'b0;
        tick();
        check("abort_mid", 32'(AluA), 4);
        check("abort_busy1", 32'(Busy), 1);
        Clear = 1'b1;
        tick();
        check("abort_busy", 32'(Busy), 0);
        check("abort_done", 32'(Done), 0);
        for (int r = 0; r < 4; r++) begin
            RdSel = 2'(r);
            #1;
            check($sformatf("abort_acc%0d", r), 32'(AluA), 0);
            check($sformatf("abort_ib%0d", r), 32'(IB), 'hF);
        end
        Clear = 1'b0;
        tick();
        check("abort_nodone", 32'(Done), 0);
        check("abort_idle", 32'(Busy), 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            Clear  = (n == 0) || ($urandom_range(0, 49) == 0);
            Latch  = ($urandom_range(0, 3) != 0);
            Op     = 3'($urandom_range(0, 7));
            WrSel  = 2'($urandom_range(0, 3));
            ShAmt  = 3'($urandom_range(0, 7));
            DataIn = 4'($urandom);
            BusIn  = 4'($urandom);
            RdSel  = 2'($urandom);
            Enable = 1'($urandom);
            modelEdge();
            tick();
            check("rnd_aluA", 32'(AluA), accM[RdSel]);
            check("rnd_ib", 32'(IB), (~accM[RdSel]) & 'hF);
            check("rnd_iboe", 32'(IBOe), int'(Enable & ~busyM));
            check("rnd_busy", 32'(Busy), int'(busyM));
            check("rnd_done", 32'(Done), int'(doneM));
            check("rnd_zero", 32'(Zero), FLAGS ? int'(zeroM) : 0);
            check("rnd_carry", 32'(Carry), FLAGS ? int'(carryM) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
